// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding and frame constants.
// ST_PARITY exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count. A push while full is taken only when a
// pop frees the head in the same cycle; a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined) feeding a byte FIFO.
// Bit timing is a down-counter reloaded per sample; a sample happens at terminal count.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = 53,
  parameter int FIFO_DEPTH        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ser_rx,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun,
  input  logic                        ovr_clr,
  output logic                        frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                        parity_err
`endif
);
  // state        | meaning
  // ST_IDLE      | line idle, waiting for a falling edge
  // ST_START     | timing to start-bit mid-point, false start if high there
  // ST_DATA      | sampling 8 data bits LSB first
  // ST_PARITY    | sampling the even-parity bit (parity build only)
  // ST_STOP      | sampling stop bit, push byte if good
  // ST_WAIT_IDLE | framing error seen, waiting for the line to return high
  localparam int CW = $clog2(2 * CLKS_PER_HALF_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(2 * CLKS_PER_HALF_BIT - 1);

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
  logic                 frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                 push, tick, rx_s, fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q, par_bit_d, parity_err_q, parity_err_d;
`endif

  assign rx_s = sync2_q;
  assign tick = (cnt_q == '0);

  always_comb begin
    sync1_d     = ser_rx;
    sync2_d     = sync1_q;
    rx_prev_d   = sync2_q;
    state_d     = state_q;
    cnt_d       = tick ? cnt_q : cnt_q - 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: if (rx_prev_q && !rx_s) begin
        state_d = ST_START;
        cnt_d   = HALF_LD;
      end
      ST_START: if (tick) begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_DATA;
          cnt_d     = FULL_LD;
          bit_idx_d = '0;
        end
      end
      ST_DATA: if (tick) begin
        shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
        cnt_d     = FULL_LD;
        bit_idx_d = bit_idx_q + 1'b1;
        if (bit_idx_q == BW'(DATA_BITS - 1)) begin
          bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
          state_d   = ST_PARITY;
`else
          state_d   = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (tick) begin
        par_bit_d = rx_s;
        cnt_d     = FULL_LD;
        state_d   = ST_STOP;
      end
`endif
      ST_STOP: if (tick) begin
`ifdef UART_RX_PARITY_EN
        parity_err_d = (bit_idx_q == '0) && (par_bit_q != ^shift_q);
`endif
        if (!rx_s) begin
          frame_err_d = 1'b1;
          state_d     = ST_WAIT_IDLE;
        end else if (bit_idx_q == BW'(STOP_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          push    = (par_bit_q == ^shift_q);
`else
          push    = 1'b1;
`endif
          state_d = ST_IDLE;
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
          cnt_d     = FULL_LD;
        end
      end
      ST_WAIT_IDLE: if (rx_s) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A clear and an overrun in the same cycle leave the flag set.
  always_comb begin
    overrun_d = overrun_q;
    if (ovr_clr) overrun_d = 1'b0;
    if (push && fifo_full && !rx_ready) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      rx_prev_q   <= rx_prev_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shift_q),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rx_valid  = !fifo_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif
endmodule
